// File: rtl/sequential_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a start/busy/done handshake.
// Define MUL_EARLY_EXIT_EN to finish as soon as no set multiplier bits remain.
module sequential_multiplier (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] multiplicand,
  input  logic [7:0] multiplier,
  output logic [7:0] product_lo,
  output logic [7:0] product_hi,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MULTIPLY = 2'b01,
    FINISH   = 2'b10
  } state_t;

  state_t      state, state_n;
  logic [15:0] p;
  logic [15:0] m;
  logic [7:0]  q;
  logic [3:0]  count;
  logic        last_step;

`ifdef MUL_EARLY_EXIT_EN
  // Stop once the bit being consumed now is the last set multiplier bit.
  assign last_step = (count == 4'd7) || (q[7:1] == 7'd0);
`else
  assign last_step = (count == 4'd7);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = MULTIPLY;
      MULTIPLY: if (last_step) state_n = FINISH;
      FINISH:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p     <= '0;
      m     <= '0;
      q     <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p     <= '0;
            m     <= {8'h00, multiplicand};
            q     <= multiplier;
            count <= '0;
          end
        end
        MULTIPLY: begin
          if (q[0]) p <= p + m;
          m     <= {m[14:0], 1'b0};
          q     <= {1'b0, q[7:1]};
          count <= count + 4'd1;
        end
        FINISH: begin
        end
        default: begin
          p     <= '0;
          m     <= '0;
          q     <= '0;
          count <= '0;
        end
      endcase
    end
  end

  assign product_lo = p[7:0];
  assign product_hi = p[15:8];
  assign busy       = (state == MULTIPLY);
  assign done       = (state == FINISH);
  assign overflow   = done && (p[15:8] != 8'h00);

endmodule
